decode_stage: RTL

- Producer end of the ALU interface: decodes one RV32I instruction per transfer into `alucode`, `op1`, `op2` and the side-band fields consumed by the execute stage.
- Sits between fetch and execute, holding a single registered pipeline slot with valid/ready handshakes on both sides.
- Owns register-file read addressing, immediate generation, operand selection, load-use bubble insertion and flush.

---
 rtl/decode_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: one registered pipeline slot between fetch and execute,
// with register-file addressing, immediate generation, operand select, load-use bubble and flush.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_alucode,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_we,
    output logic            out_is_load,
    output logic            out_illegal
);
    localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18, ALU_XOR  = 6'd19, ALU_OR   = 6'd20;
    localparam logic [5:0] ALU_AND  = 6'd21, ALU_SLL  = 6'd22, ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24, ALU_SLT  = 6'd25, ALU_SLTU = 6'd26;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic            valid;
        logic [5:0]      alucode;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_we;
        logic            is_load;
        logic            illegal;
    } slot_t;

    slot_t slot_q, slot_d, dec;
    logic  use_rs1, use_rs2, hazard, ld;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign opcode   = in_insn[6:0];
    assign funct3   = in_insn[14:12];
    assign funct7   = in_insn[31:25];
    assign rs1_addr = in_insn[19:15];
    assign rs2_addr = in_insn[24:20];

    assign imm_i = {{20{in_insn[31]}}, in_insn[31:20]};
    assign imm_s = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    assign imm_b = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
    assign imm_u = {in_insn[31:12], 12'b0};
    assign imm_j = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
    assign shamt = {27'b0, in_insn[24:20]};

    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.alucode    = ALU_ADD;
        dec.pc         = in_pc;
        dec.store_data = rs2_data;
        dec.rd         = in_insn[11:7];
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.alucode = ALU_LUI;
                dec.op2     = imm_u;
                dec.imm     = imm_u;
                dec.reg_we  = 1'b1;
            end
            OP_AUIPC: begin
                dec.op1    = in_pc;
                dec.op2    = imm_u;
                dec.imm    = imm_u;
                dec.reg_we = 1'b1;
            end
            OP_JAL: begin
                dec.alucode = ALU_JAL;
                dec.op2     = in_pc;
                dec.imm     = imm_j;
                dec.reg_we  = 1'b1;
            end
            OP_JALR: begin
                dec.alucode = ALU_JALR;
                dec.op1     = rs1_data;
                dec.op2     = in_pc;
                dec.imm     = imm_i;
                dec.reg_we  = 1'b1;
                use_rs1     = 1'b1;
                dec.illegal = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.op1 = rs1_data;
                dec.op2 = rs2_data;
                dec.imm = imm_b;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec.alucode = ALU_BEQ;
                    3'b001:  dec.alucode = ALU_BNE;
                    3'b100:  dec.alucode = ALU_BLT;
                    3'b101:  dec.alucode = ALU_BGE;
                    3'b110:  dec.alucode = ALU_BLTU;
                    3'b111:  dec.alucode = ALU_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.op1     = rs1_data;
                dec.op2     = imm_i;
                dec.imm     = imm_i;
                dec.reg_we  = 1'b1;
                dec.is_load = 1'b1;
                use_rs1     = 1'b1;
                case (funct3)
                    3'b000:  dec.alucode = ALU_LB;
                    3'b001:  dec.alucode = ALU_LH;
                    3'b010:  dec.alucode = ALU_LW;
                    3'b100:  dec.alucode = ALU_LBU;
                    3'b101:  dec.alucode = ALU_LHU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.op1 = rs1_data;
                dec.op2 = imm_s;
                dec.imm = imm_s;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec.alucode = ALU_SB;
                    3'b001:  dec.alucode = ALU_SH;
                    3'b010:  dec.alucode = ALU_SW;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.op1    = rs1_data;
                dec.op2    = imm_i;
                dec.imm    = imm_i;
                dec.reg_we = 1'b1;
                use_rs1    = 1'b1;
                case (funct3)
                    3'b000: dec.alucode = ALU_ADD;
                    3'b010: dec.alucode = ALU_SLT;
                    3'b011: dec.alucode = ALU_SLTU;
                    3'b100: dec.alucode = ALU_XOR;
                    3'b110: dec.alucode = ALU_OR;
                    3'b111: dec.alucode = ALU_AND;
                    3'b001: begin
                        dec.alucode = ALU_SLL;
                        dec.op2     = shamt;
                        dec.illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        // insn[30] picks arithmetic shift; every other funct7 bit must be clear
                        dec.alucode = in_insn[30] ? ALU_SRA : ALU_SRL;
                        dec.op2     = shamt;
                        dec.illegal = ({funct7[6], funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            OP_REG: begin
                dec.op1    = rs1_data;
                dec.op2    = rs2_data;
                dec.reg_we = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.alucode = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.alucode = ALU_SUB;
                    {7'b0000000, 3'b001}: dec.alucode = ALU_SLL;
                    {7'b0000000, 3'b010}: dec.alucode = ALU_SLT;
                    {7'b0000000, 3'b011}: dec.alucode = ALU_SLTU;
                    {7'b0000000, 3'b100}: dec.alucode = ALU_XOR;
                    {7'b0000000, 3'b101}: dec.alucode = ALU_SRL;
                    {7'b0100000, 3'b101}: dec.alucode = ALU_SRA;
                    {7'b0000000, 3'b110}: dec.alucode = ALU_OR;
                    {7'b0000000, 3'b111}: dec.alucode = ALU_AND;
                    default:              dec.illegal = 1'b1;
                endcase
            end
            OP_FENCE, OP_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase

        if (dec.illegal) begin
            dec.alucode = ALU_ADD;
            dec.op1     = '0;
            dec.op2     = '0;
            dec.imm     = '0;
            dec.reg_we  = 1'b0;
            dec.is_load = 1'b0;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
        if (!dec.reg_we || dec.rd == 5'd0) begin
            dec.reg_we = 1'b0;
            dec.rd     = 5'd0;
        end
    end

    // Only one bubble is needed: the following cycle execute forwards from memory.
    assign hazard = slot_q.valid & slot_q.is_load & (slot_q.rd != 5'd0) &
                    ((use_rs1 & (slot_q.rd == rs1_addr)) | (use_rs2 & (slot_q.rd == rs2_addr)));
    assign ld       = ~slot_q.valid | out_ready;
    assign in_ready = ld & ~hazard & ~flush;

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d.valid = 1'b0;
        end else if (ld) begin
            if (in_valid && !hazard) slot_d = dec;
            else                     slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign out_valid      = slot_q.valid;
    assign out_alucode    = slot_q.alucode;
    assign out_op1        = slot_q.op1;
    assign out_op2        = slot_q.op2;
    assign out_imm        = slot_q.imm;
    assign out_pc         = slot_q.pc;
    assign out_store_data = slot_q.store_data;
    assign out_rd         = slot_q.rd;
    assign out_reg_we     = slot_q.reg_we;
    assign out_is_load    = slot_q.is_load;
    assign out_illegal    = slot_q.illegal;
endmodule
